way_lookup_pipe: RTL

Registered, handshaked successor to the combinational way tag matcher. It decodes a request address, compares the tag against all `NUM_WAYS` way entries of the selected set, and returns hit/miss, the hit way (one-hot and binary), a multi-hit flag and a replacement victim. It keeps per-set replacement state and saturating hit/miss counters. It sits between the cache controller's request path and the tag/valid arrays, which the parent reads combinationally for `req_addr`'s set.

---
 rtl/way_lookup_pipe.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/way_lookup_pipe.sv
// Registered set-associative tag lookup with valid/ready handshakes, per-set replacement state
// and saturating hit/miss counters. Define WAY_LOOKUP_PLRU_EN for tree pseudo-LRU; default is round-robin.
module way_lookup_pipe #(
  parameter int NUM_WAYS      = 4,
  parameter int NUM_SETS      = 64,
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_SIZE    = 32,
  localparam int OFF_W = $clog2(BLOCK_SIZE),
  localparam int IDX_W = $clog2(NUM_SETS),
  localparam int TAG_W = ADDRESS_WIDTH - IDX_W - OFF_W,
  localparam int WAY_W = $clog2(NUM_WAYS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [NUM_WAYS-1:0]       way_valid,
  input  logic [NUM_WAYS*TAG_W-1:0] way_tag,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_hit,
  output logic                      rsp_miss,
  output logic [NUM_WAYS-1:0]       rsp_hit_way,
  output logic [WAY_W-1:0]          rsp_hit_idx,
  output logic                      rsp_multi_hit,
  output logic [WAY_W-1:0]          rsp_victim_way,
  output logic [IDX_W-1:0]          rsp_set,
  input  logic                      fill_valid,
  input  logic [IDX_W-1:0]          fill_set,
  input  logic [WAY_W-1:0]          fill_way,
  output logic                      err_multi_hit,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
);

  // Handshake: a request transfers on req_valid && req_ready, a response on rsp_valid && rsp_ready;
  // the single output stage may be refilled in the same cycle it drains.

`ifdef WAY_LOOKUP_PLRU_EN
  localparam int REPL_W = NUM_WAYS - 1;

  // Heap-ordered tree: node n at bit n-1, children 2n/2n+1; a set bit sends the victim right.
  function automatic logic [REPL_W-1:0] f_touch(input logic [REPL_W-1:0] s, input logic [WAY_W-1:0] w);
    logic [REPL_W-1:0] r;
    int n;
    r = s;
    n = NUM_WAYS + int'(w);
    for (int l = 0; l < WAY_W; l++) begin
      r[(n >> 1) - 1] = ~n[0];
      n = n >> 1;
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] f_victim(input logic [REPL_W-1:0] s);
    int n;
    n = 1;
    for (int l = 0; l < WAY_W; l++) n = 2 * n + (s[n-1] ? 1 : 0);
    return WAY_W'(n - NUM_WAYS);
  endfunction
`else
  localparam int REPL_W = WAY_W;
`endif

  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_set;
  logic [NUM_WAYS-1:0] w_match;
  logic [NUM_WAYS-1:0] w_hit_way;
  logic [WAY_W-1:0]    w_hit_idx;
  logic [WAY_W-1:0]    w_inv_idx;
  logic [WAY_W-1:0]    w_pol_victim;
  logic [WAY_W-1:0]    w_victim;
  logic                w_hit;
  logic                w_multi;
  logic                w_accept;
  logic                w_unused_off;
  logic [REPL_W-1:0]   w_repl_nxt [NUM_SETS];

  logic                r_live;
  logic                r_rsp_valid;
  logic                r_hit;
  logic                r_miss;
  logic [NUM_WAYS-1:0] r_hit_way;
  logic [WAY_W-1:0]    r_hit_idx;
  logic                r_multi;
  logic [WAY_W-1:0]    r_victim;
  logic [IDX_W-1:0]    r_set;
  logic                r_err;
  logic [31:0]         r_hit_cnt;
  logic [31:0]         r_miss_cnt;
  logic [REPL_W-1:0]   r_repl [NUM_SETS];

  assign w_tag        = req_addr[ADDRESS_WIDTH-1 -: TAG_W];
  assign w_set        = req_addr[OFF_W +: IDX_W];
  assign w_unused_off = ^req_addr[OFF_W-1:0];
  assign req_ready    = r_live && (!r_rsp_valid || rsp_ready);
  assign w_accept     = req_valid && req_ready;

  always_comb begin
    w_match   = '0;
    w_hit_idx = '0;
    w_inv_idx = '0;
    for (int i = 0; i < NUM_WAYS; i++)
      w_match[i] = way_valid[i] && (way_tag[i*TAG_W +: TAG_W] == w_tag);
    // Scan downward so the lowest index is the last one written.
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (w_match[i])    w_hit_idx = WAY_W'(i);
      if (!way_valid[i]) w_inv_idx = WAY_W'(i);
    end
    w_hit     = |w_match;
    w_multi   = |(w_match & (w_match - NUM_WAYS'(1)));
    w_hit_way = w_hit ? (NUM_WAYS'(1) << w_hit_idx) : '0;
  end

`ifdef WAY_LOOKUP_PLRU_EN
  assign w_pol_victim = f_victim(r_repl[w_set]);
`else
  assign w_pol_victim = r_repl[w_set];
`endif
  assign w_victim = (&way_valid) ? w_pol_victim : w_inv_idx;

  // Hit touch is applied first so a same-set fill overrides any shared bits.
  always_comb begin
    for (int s = 0; s < NUM_SETS; s++) begin
      w_repl_nxt[s] = r_repl[s];
`ifdef WAY_LOOKUP_PLRU_EN
      if (w_accept && w_hit && (w_set == IDX_W'(s)))
        w_repl_nxt[s] = f_touch(w_repl_nxt[s], w_hit_idx);
      if (fill_valid && (fill_set == IDX_W'(s)))
        w_repl_nxt[s] = f_touch(w_repl_nxt[s], fill_way);
`else
      if (fill_valid && (fill_set == IDX_W'(s)))
        w_repl_nxt[s] = fill_way + WAY_W'(1);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_live      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_hit_way   <= '0;
      r_hit_idx   <= '0;
      r_multi     <= 1'b0;
      r_victim    <= '0;
      r_set       <= '0;
      r_err       <= 1'b0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      for (int s = 0; s < NUM_SETS; s++) r_repl[s] <= '0;
    end else begin
      r_live <= 1'b1;
      for (int s = 0; s < NUM_SETS; s++) r_repl[s] <= w_repl_nxt[s];
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_hit       <= w_hit;
        r_miss      <= !w_hit;
        r_hit_way   <= w_hit_way;
        r_hit_idx   <= w_hit_idx;
        r_multi     <= w_multi;
        r_victim    <= w_victim;
        r_set       <= w_set;
        if (w_multi) r_err <= 1'b1;
        if (w_hit) begin
          if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
        end else begin
          if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid      = r_rsp_valid;
  assign rsp_hit        = r_hit;
  assign rsp_miss       = r_miss;
  assign rsp_hit_way    = r_hit_way;
  assign rsp_hit_idx    = r_hit_idx;
  assign rsp_multi_hit  = r_multi;
  assign rsp_victim_way = r_victim;
  assign rsp_set        = r_set;
  assign err_multi_hit  = r_err;
  assign hit_count      = r_hit_cnt;
  assign miss_count     = r_miss_cnt;

endmodule
